// File: rtl/bitsel_if.sv
// Request/response bundle for the bitsel unit: one request channel in, one result channel out.
// Both channels transfer on a rising clk edge where valid and ready are both high; once valid is
// raised the producer holds its payload stable until that edge, and ready never waits on valid.
interface bitsel_if;
    logic        din_valid;
    logic        din_ready;
    logic [63:0] din_data;
    logic [5:0]  din_index;
    logic [1:0]  din_func;
    logic        dout_valid;
    logic        dout_ready;
    logic [63:0] dout_data;

    modport master (
        output din_valid, din_data, din_index, din_func, dout_ready,
        input  din_ready, dout_valid, dout_data
    );

    modport slave (
        input  din_valid, din_data, din_index, din_func, dout_ready,
        output din_ready, dout_valid, dout_data
    );
endinterface

// File: rtl/bitsel.sv
// Select-bit unit: finds the position of the n-th set bit of a 64- or 32-bit operand,
// scanning one byte per clock so latency is fixed at W/8 cycles.
module bitsel (
    input  logic       clk,
    input  logic       reset,
    bitsel_if.slave    bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [63:0] data_q;
    logic [6:0]  remaining;
    logic        mode32_q;
    logic        reverse_q;
    logic        found;
    logic [5:0]  pos;
    logic [2:0]  k;

    logic [63:0] rev64;
    logic [31:0] rev32;
    logic [63:0] captured;
    logic [7:0]  chunk;
    logic [3:0]  chunk_cnt;
    logic [3:0]  seen;
    logic [2:0]  hit_idx;
    logic        hit;
    logic        next_found;
    logic [5:0]  next_pos;
    logic        last_chunk;
    logic [6:0]  width_val;
    logic [6:0]  result;

    assign bus.din_ready = (state == IDLE) && !reset;
    assign dbg_state     = state;

    // Reverse mode flips the operand within W so the scan always runs from bit 0 upward.
    always_comb begin
        rev64 = '0;
        rev32 = '0;
        for (int i = 0; i < 64; i++) rev64[i] = bus.din_data[63-i];
        for (int i = 0; i < 32; i++) rev32[i] = bus.din_data[31-i];
        case (bus.din_func)
            2'b00:   captured = bus.din_data;
            2'b01:   captured = {32'b0, bus.din_data[31:0]};
            2'b10:   captured = rev64;
            default: captured = {32'b0, rev32};
        endcase
    end

    always_comb begin
        chunk     = data_q[7:0];
        chunk_cnt = '0;
        seen      = '0;
        hit_idx   = '0;
        for (int i = 0; i < 8; i++) chunk_cnt = chunk_cnt + {3'b0, chunk[i]};
        for (int i = 0; i < 8; i++) begin
            if (chunk[i] && ({3'b0, seen} == remaining)) hit_idx = 3'(i);
            seen = seen + {3'b0, chunk[i]};
        end
        hit        = !found && (remaining < {3'b0, chunk_cnt});
        next_found = found || hit;
        next_pos   = hit ? {k, hit_idx} : pos;
        last_chunk = mode32_q ? (k == 3'd3) : (k == 3'd7);
        width_val  = mode32_q ? 7'd32 : 7'd64;
        if (!next_found)
            result = width_val;
        else if (reverse_q)
            result = width_val - 7'd1 - {1'b0, next_pos};
        else
            result = {1'b0, next_pos};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.dout_valid <= 1'b0;
            bus.dout_data  <= '0;
            found          <= 1'b0;
            k              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.din_valid) begin
                        data_q    <= captured;
                        remaining <= {1'b0, bus.din_index};
                        mode32_q  <= bus.din_func[0];
                        reverse_q <= bus.din_func[1];
                        found     <= 1'b0;
                        pos       <= '0;
                        k         <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    data_q <= {8'b0, data_q[63:8]};
                    found  <= next_found;
                    pos    <= next_pos;
                    // Once found the count is irrelevant; freezing it avoids any wrap.
                    if (!next_found) remaining <= remaining - {3'b0, chunk_cnt};
                    k <= k + 3'd1;
                    if (last_chunk) begin
                        bus.dout_data  <= {57'b0, result};
                        bus.dout_valid <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.dout_ready) begin
                        bus.dout_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitsel.sv
// Bench for bitsel: directed corner cases, output back-pressure, mid-scan reset, then random
// operations checked against a rank-walking reference model.
module tb_bitsel;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;

    bitsel_if bus ();

    bitsel dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    int          tests  = 0;
    int          failed = 0;

    // Walk bit positions in counting order and return the position where the rank is reached.
    function automatic logic [63:0] ref_sel(input logic [63:0] d, input int idx, input logic [1:0] f);
        int w;
        int seen;
        int b;
        w    = f[0] ? 32 : 64;
        seen = 0;
        for (int step = 0; step < w; step++) begin
            b = f[1] ? (w - 1 - step) : step;
            if (d[b]) begin
                if (seen == idx) return 64'(b);
                seen++;
            end
        end
        return 64'(w);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic drive_req(input logic [63:0] d, input logic [5:0] idx, input logic [1:0] f,
                             input logic [63:0] expv);
        int guard;
        guard = 0;
        exp_q.push_back(expv);
        bus.din_data  = d;
        bus.din_index = idx;
        bus.din_func  = f;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && guard < 30) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 30) check("accept_timeout", 64'(bus.din_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat, output logic [63:0] expv);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.dout_valid && lat < 40);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        expv = exp_q.pop_front();
        check(tag, bus.dout_data, expv);
    endtask

    task automatic handshake(input int delay);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        bus.dout_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] d, input logic [5:0] idx,
                          input logic [1:0] f, input logic [63:0] expv, input int delay);
        logic [63:0] got;
        drive_req(d, idx, f, expv);
        wait_valid(tag, f[0] ? 4 : 8, got);
        handshake(delay);
        check({tag, "_valid_drop"}, 64'(bus.dout_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        logic [63:0] d;
        logic [5:0]  idx;
        logic [1:0]  f;
        int          stray;

        bus.din_valid  = 1'b0;
        bus.din_data   = '0;
        bus.din_index  = '0;
        bus.din_func   = '0;
        bus.dout_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_din_ready", 64'(bus.din_ready), 64'd0);
        check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_dout_data", bus.dout_data, 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_din_ready", 64'(bus.din_ready), 64'd1);

        // Directed corner cases
        run_op("f0_idx2", 64'h0000_0000_0000_00F0, 6'd2, 2'b00, 64'd6, 0);
        run_op("msb_idx1", 64'h8000_0000_0000_0001, 6'd1, 2'b00, 64'd63, 1);
        run_op("not_found64", 64'h8000_0000_0000_0001, 6'd2, 2'b00, 64'd64, 0);
        run_op("mode32_upper", 64'hFFFF_FFFF_0000_0000, 6'd0, 2'b01, 64'd32, 0);
        run_op("rev64", 64'h0000_0000_0000_00F0, 6'd0, 2'b10, 64'd7, 0);
        run_op("rev32", 64'h0000_0001_8000_0001, 6'd0, 2'b11, 64'd31, 0);
        run_op("mode32_idx_big", 64'hFFFF_FFFF_FFFF_FFFF, 6'd40, 2'b01, 64'd32, 0);
        run_op("all_ones_63", 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 2'b00, 64'd63, 0);
        run_op("zero_op", 64'd0, 6'd0, 2'b10, 64'd64, 0);

        // Output back-pressure with a request waiting
        drive_req(64'h0000_0000_0000_00F0, 6'd2, 2'b00, 64'd6);
        wait_valid("hold", 8, held);
        bus.din_data  = 64'hFF;
        bus.din_index = 6'd7;
        bus.din_func  = 2'b00;
        bus.din_valid = 1'b1;
        exp_q.push_back(64'd7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_data", bus.dout_data, held);
            check("hold_valid", 64'(bus.dout_valid), 64'd1);
            check("hold_din_ready", 64'(bus.din_ready), 64'd0);
        end
        bus.dout_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b0;
        check("hs_valid_drop", 64'(bus.dout_valid), 64'd0);
        check("hs_idle_ready", 64'(bus.din_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        check("queued_accepted", 64'(bus.din_ready), 64'd0);
        wait_valid("queued", 8, held);
        handshake(0);

        // Reset during the third scan cycle aborts the operation
        drive_req(64'hFFFF_FFFF_FFFF_FFFF, 6'd3, 2'b00, 64'd3);
        exp_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("midrst_din_ready", 64'(bus.din_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.dout_valid) stray++;
        end
        check("midrst_no_output", 64'(stray), 64'd0);
        run_op("after_rst", 64'h0000_0000_0000_00FF, 6'd7, 2'b00, 64'd7, 0);

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            d = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: ;
                1: d = d & {$urandom(), $urandom()};
                2: d = d & {$urandom(), $urandom()} & {$urandom(), $urandom()};
                default: d = d & {$urandom(), $urandom()} & {$urandom(), $urandom()}
                             & {$urandom(), $urandom()};
            endcase
            idx = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
            f   = 2'($urandom_range(0, 3));
            run_op("random", d, idx, f, ref_sel(d, int'(idx), f), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
